// File: rtl/duart_tx_fifo.sv
// duart_tx_fifo: debug-UART transmit path.
// Bytes written by the APB register block are buffered in a DEPTH-entry FIFO.
// Each byte is sent on txd as an 8N1 frame, LSB first.
// Build option: define DUART_TX_PARITY_EN to add a parity bit (8E1/8O1) and the
// parity_odd input. Left undefined, frames are 10 bits with no parity.
// txd is registered from the current FSM state, so it lags the state by one
// cycle. A byte written into an empty FIFO therefore drives txd low on the
// second rising edge after the write.
module duart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic          tx_en,
  input  logic [15:0]   baud_div,
`ifdef DUART_TX_PARITY_EN
  input  logic          parity_odd,
`endif
  output logic          txd,
  output logic          busy,
  output logic [LW-1:0] fifo_level
);

  localparam int AW = LW - 1;

`ifdef DUART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  // FIFO storage and pointers. Each pointer carries an extra wrap bit.
  logic [7:0]    mem [DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Transmit datapath.
  state_t        state;
  state_t        state_n;
  logic [15:0]   baud_cnt;
  logic [15:0]   div_m1;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          bit_end;
  logic          load_bit;
  logic          shift_en;
  logic          txd_n;
`ifdef DUART_TX_PARITY_EN
  logic          par_bit;
`endif

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[LW-1] != rd_ptr[LW-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // No bypass: a full FIFO refuses a write even when a pop happens in the same cycle.
  assign wr_ready   = !full;
  assign push       = wr_valid && !full;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign fifo_level = level;
  assign busy       = (state != IDLE) || !empty;

  // A baud_div of 0 is treated as 1, so the shortest bit is one clock.
  assign div_m1  = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  assign bit_end = (baud_cnt == 16'd0);

  // Storage write. No reset: the contents are don't-care once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointers and the level register. A push and a pop in the same cycle leave the level unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next state, the per-bit control strobes and the next txd level.
  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    load_bit = 1'b0;
    shift_en = 1'b0;
    txd_n    = 1'b1;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        // tx_en is checked only here, so a frame already in progress always completes.
        if (tx_en && !empty) begin
          pop      = 1'b1;
          load_bit = 1'b1;
          state_n  = START;
        end
      end
      START: begin
        txd_n = 1'b0;
        if (bit_end) begin
          load_bit = 1'b1;
          state_n  = DATA;
        end
      end
      DATA: begin
        txd_n = shift[0];
        if (bit_end) begin
          load_bit = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef DUART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef DUART_TX_PARITY_EN
      PARITY: begin
        txd_n = par_bit;
        if (bit_end) begin
          load_bit = 1'b1;
          state_n  = STOP;
        end
      end
`endif
      STOP: begin
        txd_n = 1'b1;
        // The stop bit does not load the counter on exit. The next frame, if any,
        // starts from IDLE one cycle later.
        if (bit_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit timer, data shifter, parity capture and the registered txd.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef DUART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      txd <= txd_n;
      // baud_div is sampled only when a bit starts, so a change takes effect at the next bit.
      if (load_bit)               baud_cnt <= div_m1;
      else if (baud_cnt != 16'd0) baud_cnt <= baud_cnt - 16'd1;
      if (pop) begin
        shift   <= head;
        bit_cnt <= 3'd0;
`ifdef DUART_TX_PARITY_EN
        par_bit <= (^head) ^ parity_odd;
`endif
      end else if (shift_en) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_duart_tx_fifo.sv
// Testbench for duart_tx_fifo.
// Directed vectors check the exact bit timing of single frames.
// Hand-written sequences cover FIFO full, back-to-back frames and mid-frame reset.
// A random run is decoded from txd samples and checked against a byte scoreboard.
module tb_duart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int LW    = 5;
`ifdef DUART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          tx_en;
  logic [15:0]   baud_div;
`ifdef DUART_TX_PARITY_EN
  logic          parity_odd;
`endif
  logic          txd;
  logic          busy;
  logic [LW-1:0] fifo_level;

  int checks   = 0;
  int failures = 0;

  logic cap[$];
  logic bcap[$];

  typedef struct {
    logic [15:0] bd;
    int          bt;
    logic [7:0]  data;
    logic        podd;
    logic        exp_par;
    string       nm;
  } vec_t;
  vec_t vecs[$];

  duart_tx_fifo #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
`ifdef DUART_TX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .txd        (txd),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference line image of one frame, LSB first: start, data, [parity], stop.
  function automatic logic [10:0] frame_word(input logic [7:0] d);
`ifdef DUART_TX_PARITY_EN
    return {1'b1, (^d) ^ parity_odd, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  task automatic cap_run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap.push_back(txd);
      bcap.push_back(busy);
    end
  endtask

  // Scan the captured txd samples for frames and compare each one with the expected byte list.
  task automatic decode(input string nm, input int bt, input logic [7:0] exp_q[$], input bit b2b);
    int i;
    int prev;
    int bad;
    logic [10:0] act;
    i = 0;
    prev = -1;
    for (int f = 0; f < exp_q.size(); f++) begin
      while (i < cap.size() && cap[i] !== 1'b0) i++;
      if (i + NB*bt > cap.size()) begin
        chk($sformatf("%s_frame%0d_present", nm, f), 32'd0, 32'd1);
        return;
      end
      if (b2b && prev >= 0)
        chk($sformatf("%s_gap%0d", nm, f), i - prev, NB*bt + 1);
      act = '1;
      bad = 0;
      for (int b = 0; b < NB; b++) begin
        act[b] = cap[i + b*bt];
        for (int c = 0; c < bt; c++)
          if (cap[i + b*bt + c] !== act[b]) bad++;
      end
      chk($sformatf("%s_frame%0d", nm, f), {21'd0, act}, {21'd0, frame_word(exp_q[f])});
      chk($sformatf("%s_frame%0d_bitwidth", nm, f), bad, 0);
      prev = i;
      i += NB*bt;
    end
    bad = 0;
    while (i < cap.size()) begin
      if (cap[i] !== 1'b1) bad++;
      i++;
    end
    chk({nm, "_idle_after"}, bad, 0);
  endtask

  // Send one byte into an idle DUT and check every bit's level and duration against the table entry.
  task automatic run_vec(input vec_t v);
    logic [10:0] w;
    int bad;
    baud_div = v.bd;
`ifdef DUART_TX_PARITY_EN
    parity_odd = v.podd;
    w = {1'b1, v.exp_par, v.data, 1'b0};
`else
    w = {2'b11, v.data, 1'b0};
`endif
    cap.delete();
    bcap.delete();
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = v.data;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_data  = ~v.data;
    cap_run(NB*v.bt + 4);
    chk({v.nm, "_idle_edge1"}, cap[1], 1'b1);
    for (int j = 0; j < NB; j++) begin
      bad = 0;
      for (int c = 0; c < v.bt; c++)
        if (cap[2 + j*v.bt + c] !== w[j]) bad++;
      chk($sformatf("%s_bit%0d_bad_samples", v.nm, j), bad, 0);
    end
    chk({v.nm, "_busy_last_stop"}, bcap[NB*v.bt], 1'b1);
    chk({v.nm, "_busy_drop"}, bcap[NB*v.bt + 1], 1'b0);
  endtask

  initial begin
    logic [7:0] q[$];
    int bad;
    int nacc;
    int bt;
    bit got;

    resetn   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    tx_en    = 1'b1;
    baud_div = 16'd4;
`ifdef DUART_TX_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_level", fifo_level, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Directed single frames: {baud_div, bit clocks, byte, parity_odd, expected parity bit, name}
    vecs.push_back('{16'd4, 4, 8'hA5, 1'b0, 1'b0, "a5_div4"});
    vecs.push_back('{16'd0, 1, 8'hFF, 1'b0, 1'b0, "ff_div0"});
    vecs.push_back('{16'd1, 1, 8'hFF, 1'b0, 1'b0, "ff_div1"});
    vecs.push_back('{16'd3, 3, 8'h3C, 1'b0, 1'b0, "3c_div3"});
    vecs.push_back('{16'd2, 2, 8'h01, 1'b0, 1'b1, "01_div2"});
`ifdef DUART_TX_PARITY_EN
    vecs.push_back('{16'd2, 2, 8'h07, 1'b0, 1'b1, "07_even"});
    vecs.push_back('{16'd2, 2, 8'h07, 1'b1, 1'b0, "07_odd"});
`endif
    foreach (vecs[n]) run_vec(vecs[n]);
`ifdef DUART_TX_PARITY_EN
    parity_odd = 1'b0;
`endif

    // Fill the FIFO with tx_en low, hold a 17th write, then let it drain.
    tx_en    = 1'b0;
    baud_div = 16'd1;
    bad = 0;
    q.delete();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (!wr_ready) bad++;
      wr_valid = 1'b1;
      wr_data  = 8'(k);
      q.push_back(8'(k));
      @(posedge clk);
      #1 wr_valid = 1'b0;
    end
    @(negedge clk);
    chk("full_ready_while_filling", bad, 0);
    chk("full_level16", fifo_level, 16);
    chk("full_wr_ready0", wr_ready, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 8'h10;
    q.push_back(8'h10);
    repeat (3) @(negedge clk);
    chk("full_held_level", fifo_level, 16);
    chk("full_held_ready", wr_ready, 1'b0);
    cap.delete();
    bcap.delete();
    fork
      cap_run(17*(NB + 1) + 30);
      begin
        tx_en = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (wr_ready) begin
            got = 1'b1;
            break;
          end
        end
        chk("full_17th_accepted", got, 1'b1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        @(negedge clk);
        if (got) chk("full_level_after_17th", fifo_level, 16);
      end
    join
    decode("full_drain", 1, q, 1'b1);

    // Writes of 0x55 on every cycle with baud_div=2: frames must run back to back.
    baud_div = 16'd2;
    cap.delete();
    bcap.delete();
    nacc = 0;
    fork
      cap_run(40 + 20*(NB*2 + 1) + 20);
      begin
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (k == 1) chk("b2b_level_first", fifo_level, 1);
          if (k == 2) chk("b2b_level_pushpop", fifo_level, 1);
          if (k == 3) chk("b2b_level_grow", fifo_level, 2);
          wr_valid = 1'b1;
          wr_data  = 8'h55;
          if (wr_ready) nacc++;
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
      end
    join
    q.delete();
    for (int k = 0; k < nacc; k++) q.push_back(8'h55);
    decode("b2b", 2, q, 1'b1);
    chk("b2b_end_level", fifo_level, 0);

    // Reset during data bit 3 of the first of six queued frames.
    tx_en    = 1'b0;
    baud_div = 16'd4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'h38 + 8'(k);
      @(posedge clk);
      #1 wr_valid = 1'b0;
    end
    @(negedge clk);
    tx_en = 1'b1;
    repeat (19) @(negedge clk);
    chk("rstmid_level5", fifo_level, 5);
    chk("rstmid_databit3", txd, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_txd", txd, 1'b1);
    chk("rstmid_level0", fifo_level, 0);
    chk("rstmid_busy0", busy, 1'b0);
    chk("rstmid_ready", wr_ready, 1'b1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    cap.delete();
    bcap.delete();
    cap_run(60);
    bad = 0;
    foreach (cap[k]) if (cap[k] !== 1'b1) bad++;
    chk("rstmid_no_residual", bad, 0);
    chk("rstmid_busy_after", busy, 1'b0);

    // Random writes checked against the byte scoreboard.
    bt = $urandom_range(1, 3);
    baud_div = ((bt == 1) && ($urandom_range(0, 1) == 1)) ? 16'd0 : 16'(bt);
`ifdef DUART_TX_PARITY_EN
    parity_odd = 1'($urandom_range(0, 1));
`endif
    q.delete();
    bad = 0;
    cap.delete();
    bcap.delete();
    fork
      cap_run(150 + 17*(NB*3 + 1) + 40);
      begin
        for (int k = 0; k < 150; k++) begin
          @(negedge clk);
          if ((wr_ready !== (fifo_level != 5'(DEPTH))) || (fifo_level > 5'(DEPTH))) bad++;
          wr_valid = ($urandom_range(0, 9) < 6);
          wr_data  = 8'($urandom);
          if (wr_valid && wr_ready) q.push_back(wr_data);
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
      end
    join
    chk("rand_ready_vs_level", bad, 0);
    decode("rand", bt, q, 1'b0);
    chk("rand_end_level", fifo_level, 0);
    chk("rand_end_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
